or_gate_core: RTL and testbench

Two-input bitwise OR with a zero-latency combinational output plus registered observation outputs. The combinational path `y = a | b` is the primary function and is used wherever a plain OR gate is instantiated. The registered side adds a pipelined copy, a reduction flag, a sticky accumulator and a saturating hit counter for status and debug logic.

---
 rtl/or_gate_core_if.sv | 37 +++
 rtl/or_gate_core.sv | 64 ++++++
 tb/tb_or_gate_core.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/or_gate_core_if.sv
// rtl/or_gate_core_if.sv - signal bundle for or_gate_core operands, result and observation outputs
//
// Purpose: groups the operand, result and status signals of one or_gate_core
// instance so that a driver and the core can share a single handle.
// Ports (signals):
//   a, b      - operands (WIDTH)
//   y         - combinational a | b (WIDTH)
//   clr       - synchronous clear of sticky_q / hit_cnt
//   y_q       - registered a | b (WIDTH)
//   any_q     - registered reduction-OR of a | b
//   sticky_q  - per-bit OR accumulation (WIDTH)
//   hit_cnt   - saturating count of cycles with any bit set (CNT_W)
// Modports: master drives operands and clr; slave is the core side.

interface or_gate_core_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             clr;
  logic [WIDTH-1:0] y_q;
  logic             any_q;
  logic [WIDTH-1:0] sticky_q;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output a, b, clr,
    input  y, y_q, any_q, sticky_q, hit_cnt
  );

  modport slave (
    input  a, b, clr,
    output y, y_q, any_q, sticky_q, hit_cnt
  );
endinterface

// File: rtl/or_gate_core.sv
// rtl/or_gate_core.sv - bitwise OR with registered copy, reduction flag, sticky accumulator and hit counter
//
// Purpose: y = a | b is the zero-latency primary output and depends on nothing
// but a and b. The clocked side keeps a pipelined copy, a reduction flag, a
// per-bit sticky accumulator and a saturating hit counter for status/debug.
// Ports (a, b, y first so a positional (a, b, y) hookup works as a plain gate):
//   a, b      in  WIDTH  operands
//   y         out WIDTH  combinational a | b
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset of all registers
//   clr       in  1      synchronous clear of sticky_q and hit_cnt
//   y_q       out WIDTH  a | b sampled at the previous edge
//   any_q     out 1      |(a | b) sampled at the previous edge
//   sticky_q  out WIDTH  OR of every y since the last reset or clear
//   hit_cnt   out CNT_W  cycles with any bit set, saturating at all-ones

module or_gate_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [WIDTH-1:0] y_q,
  output logic             any_q,
  output logic [WIDTH-1:0] sticky_q,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic any;

  // No masking: X/Z on an operand propagates with plain | semantics.
  assign y   = a | b;
  assign any = |y;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      any_q    <= 1'b0;
      sticky_q <= '0;
      hit_cnt  <= '0;
    end else begin
      // The pipelined copy follows the inputs even while clr is asserted.
      y_q   <= y;
      any_q <= any;
      if (clr) begin
        // clr beats a same-cycle hit: that hit is neither counted nor accumulated.
        sticky_q <= '0;
        hit_cnt  <= '0;
      end else begin
        sticky_q <= sticky_q | y;
        if (any && (hit_cnt != CNT_MAX)) begin
          hit_cnt <= hit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_or_gate_core.sv
// tb/tb_or_gate_core.sv - self-checking bench for or_gate_core with directed and random stimulus

module tb_or_gate_core;

  localparam int CNT_W4 = 2;
  localparam int CMAX4  = (1 << CNT_W4) - 1;

  logic clk;
  logic clk_en;
  logic rst;

  int n_checks;
  int n_fail;

  // Reference state for the 4-bit instance
  int m_yq;
  int m_any;
  int m_sticky;
  int m_cnt;

  or_gate_core_if #(.WIDTH(1), .CNT_W(8))      if1 ();
  or_gate_core_if #(.WIDTH(4), .CNT_W(CNT_W4)) if4 ();

  or_gate_core #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .a        (if1.a),
    .b        (if1.b),
    .y        (if1.y),
    .clk      (clk),
    .rst      (rst),
    .clr      (if1.clr),
    .y_q      (if1.y_q),
    .any_q    (if1.any_q),
    .sticky_q (if1.sticky_q),
    .hit_cnt  (if1.hit_cnt)
  );

  or_gate_core #(.WIDTH(4), .CNT_W(CNT_W4)) u_w4 (
    .a        (if4.a),
    .b        (if4.b),
    .y        (if4.y),
    .clk      (clk),
    .rst      (rst),
    .clr      (if4.clr),
    .y_q      (if4.y_q),
    .any_q    (if4.any_q),
    .sticky_q (if4.sticky_q),
    .hit_cnt  (if4.hit_cnt)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Behavioural model: arithmetic on the operand values sampled at each edge.
  always @(posedge clk) begin
    int ab;
    ab = int'(if4.a) | int'(if4.b);
    if (rst) begin
      m_yq = 0; m_any = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      m_yq  = ab;
      m_any = (ab != 0) ? 1 : 0;
      if (if4.clr) begin
        m_sticky = 0;
        m_cnt    = 0;
      end else begin
        m_sticky = m_sticky | ab;
        if (m_any == 1) m_cnt = (m_cnt + 1 > CMAX4) ? CMAX4 : m_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".y_q"},      32'(if4.y_q),      32'(m_yq));
    check({tag, ".any_q"},    32'(if4.any_q),    32'(m_any));
    check({tag, ".sticky_q"}, 32'(if4.sticky_q), 32'(m_sticky));
    check({tag, ".hit_cnt"},  32'(if4.hit_cnt),  32'(m_cnt));
  endtask

  // Drive one cycle of stimulus on the 4-bit instance, check y before the edge
  // and the registered outputs just after it.
  task automatic step(input string tag, input logic [3:0] a_v, input logic [3:0] b_v,
                      input logic clr_v, input logic rst_v);
    @(negedge clk);
    if4.a   = a_v;
    if4.b   = b_v;
    if4.clr = clr_v;
    rst     = rst_v;
    #1;
    check({tag, ".y"}, 32'(if4.y), 32'(int'(a_v) | int'(b_v)));
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [1:0] tt_y_exp;
    logic [3:0] sat_seq [6];
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    rst      = 1'b1;
    if1.a = 1'b0; if1.b = 1'b0; if1.clr = 1'b0;
    if4.a = '0;   if4.b = '0;   if4.clr = 1'b0;

    // Truth table with the clock stopped
    for (int i = 0; i < 4; i++) begin
      if1.a = i[1];
      if1.b = i[0];
      #10;
      tt_y_exp = (i == 0) ? 2'd0 : 2'd1;
      check($sformatf("tt%0d.y", i), 32'(if1.y), 32'(tt_y_exp));
    end

    clk_en = 1'b1;

    // Reset for two cycles with all operands high
    if1.a = 1'b1; if1.b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step("reset", 4'hF, 4'hF, 1'b0, 1'b1);
      check("reset.w1_y", 32'(if1.y), 32'd1);
      check("reset.w1_y_q", 32'(if1.y_q), 32'd0);
      check("reset.w1_hit_cnt", 32'(if1.hit_cnt), 32'd0);
    end
    check("reset.sticky_zero", 32'(if4.sticky_q), 32'd0);

    // Pipeline
    step("pipe", 4'b0101, 4'b0010, 1'b0, 1'b0);
    check("pipe.y_q_const", 32'(if4.y_q), 32'h7);
    check("pipe.any_q_const", 32'(if4.any_q), 32'd1);

    // Sticky and count from a cleared state
    step("pre_clr", 4'b0000, 4'b0000, 1'b1, 1'b0);
    step("stk0", 4'b0001, 4'b0000, 1'b0, 1'b0);
    step("stk1", 4'b0100, 4'b0000, 1'b0, 1'b0);
    step("stk2", 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("stk.sticky_const", 32'(if4.sticky_q), 32'h5);
    check("stk.cnt_const", 32'(if4.hit_cnt), 32'd2);
    check("stk.any_q_zero", 32'(if4.any_q), 32'd0);

    // Clear beats a same-cycle hit
    step("clr", 4'b0001, 4'b0000, 1'b1, 1'b0);
    check("clr.sticky_const", 32'(if4.sticky_q), 32'd0);
    check("clr.cnt_const", 32'(if4.hit_cnt), 32'd0);
    check("clr.y_q_const", 32'(if4.y_q), 32'd1);

    // Saturation at CNT_W = 2
    sat_seq = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
    for (int i = 0; i < 6; i++) begin
      step("sat", 4'b0001, 4'b0000, 1'b0, 1'b0);
      check($sformatf("sat%0d.cnt_const", i), 32'(if4.hit_cnt), 32'(sat_seq[i]));
    end

    // Reset and clear together
    step("rst_clr", 4'hF, 4'h0, 1'b1, 1'b1);
    check("rst_clr.y_q_const", 32'(if4.y_q), 32'd0);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rnd%0d", i), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
